// File: rtl/demux1in2_buf_pkg.sv
// demux1in2_buf_pkg: shared constants for the buffered 1-to-2 word demux
package demux1in2_buf_pkg;
  localparam int THELLESIA = 2;
  localparam int NIVELI_W = 2;
  localparam int KANALI0 = 0;
  localparam int KANALI1 = 1;
endpackage

// File: rtl/demux1in2_buf_fifo2_buf.sv
// fifo2_buf: 2-entry registered FIFO with valid/ready pop side
// Ports: clk_i/rst_i (async active-high), push_i + data_i write side,
// pop_i consumer ready, data_o head word, valid_o non-empty, full_o, level_o occupancy.
module fifo2_buf
  import demux1in2_buf_pkg::*;
#(
  parameter int W = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                push_i,
  input  logic [W-1:0]        data_i,
  input  logic                pop_i,
  output logic [W-1:0]        data_o,
  output logic                valid_o,
  output logic                full_o,
  output logic [NIVELI_W-1:0] level_o
);
  logic [W-1:0] mem_q [THELLESIA];
  logic wptr_q, rptr_q;
  logic [NIVELI_W-1:0] level_q, level_d;
  logic wr, rd;
  assign valid_o = level_q != '0;
  assign full_o = level_q == NIVELI_W'(THELLESIA);
  assign level_o = level_q;
  assign data_o = mem_q[rptr_q];
  // full is never bypassed by a concurrent pop
  assign wr = push_i & ~full_o;
  assign rd = pop_i & valid_o;
  always_comb
    level_d = (wr & ~rd) ? level_q + NIVELI_W'(1) :
              (rd & ~wr) ? level_q - NIVELI_W'(1) : level_q;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      mem_q <= '{default: '0};
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
      level_q <= '0;
    end else begin
      if (wr) mem_q[wptr_q] <= data_i;
      wptr_q <= wptr_q ^ wr;
      rptr_q <= rptr_q ^ rd;
      level_q <= level_d;
    end
endmodule

// File: rtl/demux1in2_buf.sv
// demux1in2_buf: routes one producer word stream into one of two buffered channels
// Ports: Clock/Reset (async active-high), Hyrja+S+HyrjaValid/HyrjaReady producer side,
// DaljaN/DaljaNValid/DaljaNReady consumer channels, NiveliN channel occupancy.
module demux1in2_buf
  import demux1in2_buf_pkg::*;
#(
  parameter int GJERESIA = 2
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [GJERESIA-1:0] Hyrja,
  input  logic                S,
  input  logic                HyrjaValid,
  output logic                HyrjaReady,
  output logic [GJERESIA-1:0] Dalja0,
  output logic                Dalja0Valid,
  input  logic                Dalja0Ready,
  output logic [GJERESIA-1:0] Dalja1,
  output logic                Dalja1Valid,
  input  logic                Dalja1Ready,
  output logic [NIVELI_W-1:0] Niveli0,
  output logic [NIVELI_W-1:0] Niveli1
);
  logic full0, full1, push0, push1;
  // ready looks only at S and registered occupancy, never at the consumers
  assign HyrjaReady = S ? ~full1 : ~full0;
  assign push0 = HyrjaValid & (S == 1'(KANALI0)) & ~full0;
  assign push1 = HyrjaValid & (S == 1'(KANALI1)) & ~full1;
  fifo2_buf #(.W(GJERESIA)) u_ch0 (
    .clk_i(Clock), .rst_i(Reset), .push_i(push0), .data_i(Hyrja), .pop_i(Dalja0Ready),
    .data_o(Dalja0), .valid_o(Dalja0Valid), .full_o(full0), .level_o(Niveli0)
  );
  fifo2_buf #(.W(GJERESIA)) u_ch1 (
    .clk_i(Clock), .rst_i(Reset), .push_i(push1), .data_i(Hyrja), .pop_i(Dalja1Ready),
    .data_o(Dalja1), .valid_o(Dalja1Valid), .full_o(full1), .level_o(Niveli1)
  );
endmodule

// File: tb/tb_demux1in2_buf.sv
// tb_demux1in2_buf: directed and soak checks for demux1in2_buf
module tb_demux1in2_buf;
  localparam int W = 2;
  logic Clock = 1'b0;
  logic Reset = 1'b1;
  logic [W-1:0] Hyrja = '0;
  logic S = 1'b0;
  logic HyrjaValid = 1'b0;
  logic HyrjaReady;
  logic [W-1:0] Dalja0, Dalja1;
  logic Dalja0Valid, Dalja1Valid;
  logic Dalja0Ready = 1'b0;
  logic Dalja1Ready = 1'b0;
  logic [1:0] Niveli0, Niveli1;
  int errors = 0;
  int checks = 0;

  demux1in2_buf #(.GJERESIA(W)) dut (
    .Clock(Clock), .Reset(Reset), .Hyrja(Hyrja), .S(S), .HyrjaValid(HyrjaValid),
    .HyrjaReady(HyrjaReady), .Dalja0(Dalja0), .Dalja0Valid(Dalja0Valid),
    .Dalja0Ready(Dalja0Ready), .Dalja1(Dalja1), .Dalja1Valid(Dalja1Valid),
    .Dalja1Ready(Dalja1Ready), .Niveli0(Niveli0), .Niveli1(Niveli1)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic test_reset();
    @(negedge Clock);
    Reset = 1'b0;
    chk("rst_ready", 8'(HyrjaReady), 8'd1);
    chk("rst_v0", 8'(Dalja0Valid), 8'd0);
    chk("rst_v1", 8'(Dalja1Valid), 8'd0);
    chk("rst_n0", 8'(Niveli0), 8'd0);
    chk("rst_d1", 8'(Dalja1), 8'd0);
    S = 1'b0; HyrjaValid = 1'b1; Hyrja = 2'b01;
    @(negedge Clock);
    Hyrja = 2'b10;
    @(negedge Clock);
    HyrjaValid = 1'b0;
    chk("fill_n0", 8'(Niveli0), 8'd2);
    chk("fill_d0", 8'(Dalja0), 8'h1);
    #2 Reset = 1'b1;
    #1;
    chk("midrst_v0", 8'(Dalja0Valid), 8'd0);
    chk("midrst_n0", 8'(Niveli0), 8'd0);
    chk("midrst_d0", 8'(Dalja0), 8'd0);
    #1 Reset = 1'b0;
    @(negedge Clock);
    chk("postrst_ready", 8'(HyrjaReady), 8'd1);
    chk("postrst_n0", 8'(Niveli0), 8'd0);
  endtask

  task automatic test_routing();
    S = 1'b1; Hyrja = 2'b11; HyrjaValid = 1'b1; Dalja1Ready = 1'b0;
    @(negedge Clock);
    HyrjaValid = 1'b0;
    chk("route_v1", 8'(Dalja1Valid), 8'd1);
    chk("route_d1", 8'(Dalja1), 8'h3);
    chk("route_n1", 8'(Niveli1), 8'd1);
    chk("route_v0", 8'(Dalja0Valid), 8'd0);
    chk("route_n0", 8'(Niveli0), 8'd0);
    Dalja1Ready = 1'b1;
    @(negedge Clock);
    Dalja1Ready = 1'b0;
    chk("route_drain_n1", 8'(Niveli1), 8'd0);
  endtask

  task automatic test_backpressure();
    S = 1'b0; Dalja0Ready = 1'b0; HyrjaValid = 1'b1; Hyrja = 2'b01;
    @(negedge Clock);
    Hyrja = 2'b10;
    @(negedge Clock);
    Hyrja = 2'b11;
    chk("bp_ready", 8'(HyrjaReady), 8'd0);
    chk("bp_n0", 8'(Niveli0), 8'd2);
    chk("bp_d0", 8'(Dalja0), 8'h1);
    @(negedge Clock);
    chk("bp_hold_n0", 8'(Niveli0), 8'd2);
    chk("bp_hold_d0", 8'(Dalja0), 8'h1);
    chk("bp_hold_v0", 8'(Dalja0Valid), 8'd1);
    Dalja0Ready = 1'b1;
    @(negedge Clock);
    chk("bp_pop1_d0", 8'(Dalja0), 8'h2);
    chk("bp_pop1_n0", 8'(Niveli0), 8'd1);
    chk("bp_pop1_ready", 8'(HyrjaReady), 8'd1);
    @(negedge Clock);
    HyrjaValid = 1'b0;
    chk("bp_pop2_d0", 8'(Dalja0), 8'h3);
    chk("bp_pop2_n0", 8'(Niveli0), 8'd1);
    @(negedge Clock);
    Dalja0Ready = 1'b0;
    chk("bp_empty_v0", 8'(Dalja0Valid), 8'd0);
    chk("bp_empty_n0", 8'(Niveli0), 8'd0);
  endtask

  task automatic test_push_pop();
    S = 1'b1; Hyrja = 2'b00; HyrjaValid = 1'b1; Dalja1Ready = 1'b0;
    @(negedge Clock);
    chk("pp_pre_n1", 8'(Niveli1), 8'd1);
    chk("pp_pre_d1", 8'(Dalja1), 8'h0);
    Hyrja = 2'b10; Dalja1Ready = 1'b1;
    @(negedge Clock);
    HyrjaValid = 1'b0;
    chk("pp_n1", 8'(Niveli1), 8'd1);
    chk("pp_d1", 8'(Dalja1), 8'h2);
    @(negedge Clock);
    Dalja1Ready = 1'b0;
    chk("pp_drain_n1", 8'(Niveli1), 8'd0);
  endtask

  task automatic test_interleave();
    Dalja0Ready = 1'b1; Dalja1Ready = 1'b1; HyrjaValid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [1:0] w;
      w = 2'(i);
      S = w[0]; Hyrja = w;
      chk("il_ready", 8'(HyrjaReady), 8'd1);
      @(negedge Clock);
      if (w[0]) begin
        chk("il_v1", 8'(Dalja1Valid), 8'd1);
        chk("il_d1", 8'(Dalja1), 8'(w));
        chk("il_other_v0", 8'(Dalja0Valid), 8'd0);
      end else begin
        chk("il_v0", 8'(Dalja0Valid), 8'd1);
        chk("il_d0", 8'(Dalja0), 8'(w));
        chk("il_other_v1", 8'(Dalja1Valid), 8'd0);
      end
    end
    HyrjaValid = 1'b0;
    @(negedge Clock);
    chk("il_end_n0", 8'(Niveli0), 8'd0);
    chk("il_end_n1", 8'(Niveli1), 8'd0);
  endtask

  task automatic test_soak();
    logic [W-1:0] q0[$], q1[$];
    logic pop0, pop1, push;
    for (int c = 0; c < 2000; c++) begin
      chk("soak_n0", 8'(Niveli0), 8'(q0.size()));
      chk("soak_n1", 8'(Niveli1), 8'(q1.size()));
      chk("soak_v0", 8'(Dalja0Valid), 8'(q0.size() != 0));
      chk("soak_v1", 8'(Dalja1Valid), 8'(q1.size() != 0));
      if (q0.size() != 0) chk("soak_d0", 8'(Dalja0), 8'(q0[0]));
      if (q1.size() != 0) chk("soak_d1", 8'(Dalja1), 8'(q1[0]));
      HyrjaValid = 1'($urandom_range(0, 1));
      S = 1'($urandom_range(0, 1));
      Hyrja = W'($urandom);
      Dalja0Ready = ($urandom_range(0, 2) != 0);
      Dalja1Ready = ($urandom_range(0, 2) == 0);
      #1;
      chk("soak_ready", 8'(HyrjaReady), 8'(S ? q1.size() != 2 : q0.size() != 2));
      pop0 = Dalja0Ready && q0.size() != 0;
      pop1 = Dalja1Ready && q1.size() != 0;
      push = HyrjaValid && (S ? q1.size() != 2 : q0.size() != 2);
      if (pop0) void'(q0.pop_front());
      if (pop1) void'(q1.pop_front());
      if (push && !S) q0.push_back(Hyrja);
      if (push && S) q1.push_back(Hyrja);
      @(negedge Clock);
    end
    HyrjaValid = 1'b0; Dalja0Ready = 1'b0; Dalja1Ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_routing();
    test_backpressure();
    test_push_pop();
    test_interleave();
    test_soak();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
